// File: rtl/fuzz_round_ctrl.sv
// Fuzzing-round sequencer: holds the DUT in reset, runs it, detects pass/timeout, drains and reloads.
// Optional macro FUZZ_COV_STALL_EN compiles in coverage-stall detection as an extra interrupt source.
module fuzz_round_ctrl #(
   parameter int COV_W          = 30,
   parameter int MAX_WAIT_CYCLE = 1000,
   parameter int WATCHDOG_LIMIT = 50000,
   parameter int RESET_HOLD     = 4,
   parameter int DRAIN_CYCLES   = 5
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [63:0]       tohost,
   input  logic [COV_W-1:0]  cov,
   input  logic              reload_ack,
   input  logic              halt_req,
   output logic              dut_reset,
   output logic              clock_en,
   output logic              reload_req,
   output logic              interrupt,
   output logic              round_done,
   output logic [1:0]        round_result,
   output logic [31:0]       round_count,
   output logic              halted
);

   typedef enum logic [2:0] {HOLD, RUN, DRAIN, RELOAD, HALT} state_t;

   state_t      state, state_nxt;
   logic [31:0] phase_cnt;
   logic [31:0] watchdog;
   logic        halt_latch;
   logic        pass_hit, wd_hit, wd_near, run_exit, stall_hit;

   function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] lim);
      return (v >= lim) ? v : v + 32'd1;
   endfunction

   assign pass_hit = tohost[0];
   assign wd_hit   = watchdog >= 32'(WATCHDOG_LIMIT);
   assign wd_near  = watchdog >= 32'(WATCHDOG_LIMIT - 1);
   assign run_exit = (state == RUN) && (pass_hit || wd_hit);

`ifdef FUZZ_COV_STALL_EN
   logic [COV_W-1:0] pre_cov;
   logic [31:0]      stall_cnt;
   logic [31:0]      stall_thr;
   logic             unused_inputs;

   // Threshold scales with coverage: one MAX_WAIT_CYCLE step per 2^19 of coverage sum.
   assign stall_thr     = 32'(MAX_WAIT_CYCLE) * (32'(cov >> 19) + 32'd1);
   assign stall_hit     = stall_cnt >= stall_thr;
   assign unused_inputs = ^tohost[63:1];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pre_cov   <= '0;
         stall_cnt <= '0;
      end else if (state == RUN) begin
         if (cov != pre_cov) begin
            pre_cov   <= cov;
            stall_cnt <= '0;
         end else begin
            stall_cnt <= sat_inc(stall_cnt, 32'hFFFF_FFFF);
         end
      end else begin
         pre_cov   <= '0;
         stall_cnt <= '0;
      end
   end
`else
   logic unused_inputs;

   assign stall_hit     = 1'b0;
   assign unused_inputs = ^{tohost[63:1], cov};
`endif

   always_comb begin
      state_nxt  = state;
      dut_reset  = 1'b1;
      clock_en   = 1'b0;
      reload_req = 1'b0;
      halted     = 1'b0;
      case (state)
         HOLD: begin
            clock_en = 1'b1;
            if (phase_cnt == 32'(RESET_HOLD - 1)) state_nxt = RUN;
         end
         RUN: begin
            dut_reset = 1'b0;
            clock_en  = 1'b1;
            if (pass_hit || wd_hit) state_nxt = DRAIN;
         end
         DRAIN: begin
            if (phase_cnt == 32'(DRAIN_CYCLES - 1)) state_nxt = halt_latch ? HALT : RELOAD;
         end
         RELOAD: begin
            reload_req = 1'b1;
            if (reload_ack) state_nxt = HOLD;
         end
         HALT: begin
            halted = 1'b1;
         end
         default: state_nxt = HOLD;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= HOLD;
         phase_cnt    <= '0;
         watchdog     <= '0;
         halt_latch   <= 1'b0;
         interrupt    <= 1'b0;
         round_done   <= 1'b0;
         round_result <= 2'b00;
         round_count  <= '0;
      end else begin
         state      <= state_nxt;
         halt_latch <= halt_latch | halt_req;
         round_done <= 1'b0;

         // Phase counter times HOLD and DRAIN; restarts on every state change.
         if ((state_nxt == state) && ((state == HOLD) || (state == DRAIN)))
            phase_cnt <= phase_cnt + 32'd1;
         else
            phase_cnt <= '0;

         if (state == RUN)
            watchdog <= sat_inc(watchdog, 32'(WATCHDOG_LIMIT));
         else
            watchdog <= '0;

         if (state == RUN) begin
            if (pass_hit || wd_hit)
               interrupt <= 1'b0;
            else if (stall_hit || wd_near)
               interrupt <= 1'b1;
         end else begin
            interrupt <= 1'b0;
         end

         if (run_exit) begin
            round_done   <= 1'b1;
            round_result <= pass_hit ? 2'b01 : 2'b10;
            round_count  <= round_count + 32'd1;
         end
      end
   end

endmodule
